// File: rtl/npc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : npc_ctrl_fsm
//  Description : Multi-cycle sequencer for the RV64 NPC core. Steps each
//                instruction through FETCH, DECODE, EXEC, MEM and WB. It owns
//                the PC and the retired-instruction counter, and it drives the
//                IR load, register-file write and data-memory strobes from the
//                latched opcode. The core halts on ebreak. It traps on an
//                illegal opcode or on a memory handshake timeout.
//  Ports       : clk, rst          - clock, async active-high reset
//                opcode            - inst[6:0], sampled in DECODE
//                next_pc           - execute's PC result, used in MEM/WB
//                ifetch_ack        - instruction memory handshake
//                dmem_ack          - data memory handshake
//                pc, instret       - architectural PC / retired count
//                ifetch_req, ir_we, dmem_req, dmem_we, rf_we - strobes
//                halt, trap        - sticky terminal indications
//                state             - debug state code
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_ctrl_fsm #(
    parameter logic [63:0] RESET_PC    = 64'h8000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [63:0] next_pc,
    input  logic        ifetch_ack,
    input  logic        dmem_ack,
    output logic [63:0] pc,
    output logic        ifetch_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        halt,
    output logic        trap,
    output logic [2:0]  state,
    output logic [63:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_OP32   = 7'b0111011;
    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    // The counter only has to reach MEM_TIMEOUT-1 before the trap fires.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_WAIT_LAST =
        CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    state_t           r_state;
    logic [6:0]       r_op;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [63:0]      r_pc;
    logic [63:0]      r_instret;

    logic w_legal;
    logic w_timeout;

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            c_OP_LOAD, c_OP_IMM, c_OP_STORE, c_OP_AUIPC, c_OP_JAL,
            c_OP_JALR, c_OP_OP32, c_OP_OP, c_OP_BRANCH: w_legal = 1'b1;
            default:                                    w_legal = 1'b0;
        endcase
    end

    // A timeout of 0 means the handshake may wait forever.
    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_op       <= 7'd0;
            r_wait_cnt <= '0;
            r_pc       <= RESET_PC;
            r_instret  <= 64'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // An ack in the last allowed cycle still wins over the trap.
                    if (ifetch_ack) begin
                        r_state    <= S_DECODE;
                        r_wait_cnt <= '0;
                    end else if (w_timeout) begin
                        r_state    <= S_TRAP;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    r_op       <= opcode;
                    r_wait_cnt <= '0;
                    if (opcode == c_OP_SYSTEM) begin
                        r_state <= S_HALT;
                    end else if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    r_wait_cnt <= '0;
                    if (r_op == c_OP_LOAD || r_op == c_OP_STORE) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_wait_cnt <= '0;
                        // A store has nothing to write back, so it retires here.
                        if (r_op == c_OP_STORE) begin
                            r_pc      <= next_pc;
                            r_instret <= r_instret + 64'd1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_state   <= S_WB;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_TRAP;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    r_pc       <= next_pc;
                    r_instret  <= r_instret + 64'd1;
                    r_wait_cnt <= '0;
                    r_state    <= S_FETCH;
                end
                S_HALT, S_TRAP: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state    <= S_TRAP;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Strobes are decoded from registered state only. The single exception is
    // ir_we, which must follow the fetch ack in the same cycle.
    always_comb begin
        ifetch_req = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        halt       = 1'b0;
        trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                ifetch_req = 1'b1;
                ir_we      = ifetch_ack;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_op == c_OP_STORE);
            end
            S_WB:    rf_we = (r_op != c_OP_BRANCH);
            S_HALT:  halt  = 1'b1;
            S_TRAP:  trap  = 1'b1;
            default: ;
        endcase
    end

    assign pc      = r_pc;
    assign instret = r_instret;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_npc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npc_ctrl_fsm
//  Description : Self-checking bench for npc_ctrl_fsm. A transaction-level
//                model expands each instruction into an expected cycle trace,
//                and the DUT is compared against that trace every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_ctrl_fsm;

    localparam logic [63:0] c_RESET_PC = 64'h8000_0000;
    localparam int          c_TIMEOUT  = 16;
    localparam logic [6:0]  c_LOAD  = 7'b0000011;
    localparam logic [6:0]  c_STORE = 7'b0100011;
    localparam logic [6:0]  c_ADDI  = 7'b0010011;
    localparam logic [6:0]  c_BR    = 7'b1100011;
    localparam logic [6:0]  c_EBRK  = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [63:0] next_pc = 64'd0;
    logic        ifetch_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [63:0] pc, instret;
    logic        ifetch_req, ir_we, dmem_req, dmem_we, rf_we, halt, trap;
    logic [2:0]  state;

    npc_ctrl_fsm #(.RESET_PC(c_RESET_PC), .MEM_TIMEOUT(c_TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .next_pc(next_pc),
        .ifetch_ack(ifetch_ack), .dmem_ack(dmem_ack), .pc(pc),
        .ifetch_req(ifetch_req), .ir_we(ir_we), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .rf_we(rf_we), .halt(halt), .trap(trap),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, act, exp);
    endtask

    // One expected cycle: control vector, architectural state, and the inputs
    // to apply in that cycle.
    typedef struct {
        logic [9:0]  ctl;
        logic [63:0] pc;
        logic [63:0] ir;
        logic        iack;
        logic        dack;
        logic [6:0]  op;
        logic [63:0] npc;
    } rec_t;

    rec_t        q[$];
    logic [63:0] m_pc      = c_RESET_PC;
    logic [63:0] m_instret = 64'd0;
    int          m_mode    = 0;     // 0 running, 1 halted, 2 trapped
    logic [6:0]  legal_ops[9] = '{7'b0000011, 7'b0010011, 7'b0100011, 7'b0010111,
                                  7'b1101111, 7'b1100111, 7'b0111011, 7'b0110011,
                                  7'b1100011};

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input logic [2:0] st, input bit ifr, input bit irw, input bit dr,
                        input bit dw, input bit rfw, input bit iack, input bit dack,
                        input logic [6:0] op, input logic [63:0] npc);
        rec_t r;
        r.ctl  = {st, ifr, irw, dr, dw, rfw, (st == 3'd5), (st == 3'd6)};
        r.pc   = m_pc;
        r.ir   = m_instret;
        r.iack = iack;
        r.dack = dack;
        r.op   = op;
        r.npc  = npc;
        q.push_back(r);
    endtask

    // Cycles spent in HALT/TRAP: inputs are random noise, nothing may move.
    task automatic build_idle(input int n);
        for (int i = 0; i < n; i++)
            push((m_mode == 1) ? 3'd5 : 3'd6, 0, 0, 0, 0, 0, 1'($urandom), 1'($urandom),
                 rnd_op(), {$urandom, $urandom});
    endtask

    // Expand one instruction (fetch waits fd cycles, memory waits md cycles).
    task automatic build_instr(input logic [6:0] op, input logic [63:0] npc,
                               input int fd, input int md);
        bit ok;
        if (m_mode != 0) return;
        ok = 0;
        for (int i = 0; i <= fd; i++) begin
            if (i == fd) begin
                push(3'd0, 1, 1, 0, 0, 0, 1, 0, rnd_op(), npc);
                ok = 1;
            end else begin
                push(3'd0, 1, 0, 0, 0, 0, 0, 0, rnd_op(), npc);
                if (i == c_TIMEOUT - 1) break;
            end
        end
        if (!ok) begin m_mode = 2; return; end
        push(3'd1, 0, 0, 0, 0, 0, 0, 0, op, npc);
        if (op == c_EBRK) begin m_mode = 1; return; end
        if (!is_legal(op)) begin m_mode = 2; return; end
        push(3'd2, 0, 0, 0, 0, 0, 0, 0, rnd_op(), npc);
        if (op == c_LOAD || op == c_STORE) begin
            ok = 0;
            for (int i = 0; i <= md; i++) begin
                if (i == md) begin
                    push(3'd3, 0, 0, 1, op == c_STORE, 0, 0, 1, rnd_op(), npc);
                    ok = 1;
                end else begin
                    push(3'd3, 0, 0, 1, op == c_STORE, 0, 0, 0, rnd_op(), npc);
                    if (i == c_TIMEOUT - 1) break;
                end
            end
            if (!ok) begin m_mode = 2; return; end
            if (op == c_STORE) begin
                m_pc = npc;
                m_instret = m_instret + 64'd1;
                return;
            end
        end
        push(3'd4, 0, 0, 0, 0, op != c_BR, 0, 0, rnd_op(), npc);
        m_pc = npc;
        m_instret = m_instret + 64'd1;
    endtask

    // Entered and left at a falling edge.
    task automatic play(input int n);
        rec_t r;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            r = q.pop_front();
            opcode     = r.op;
            next_pc    = r.npc;
            ifetch_ack = r.iack;
            dmem_ack   = r.dack;
            #1;
            check_eq("ctl", {54'd0, state, ifetch_req, ir_we, dmem_req, dmem_we, rf_we, halt, trap},
                     {54'd0, r.ctl});
            check_eq("pc", pc, r.pc);
            check_eq("instret", instret, r.ir);
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ifetch_ack = 1'b0;
        dmem_ack   = 1'b0;
        opcode     = rnd_op();
        q.delete();
        m_pc      = c_RESET_PC;
        m_instret = 64'd0;
        m_mode    = 0;
        #1;
        check_eq("rst_ctl", {54'd0, state, ifetch_req, ir_we, dmem_req, dmem_we, rf_we, halt, trap},
                 {54'd0, 10'b000_1000000});
        check_eq("rst_pc", pc, c_RESET_PC);
        check_eq("rst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int fd, md, sel;
        logic [6:0]  op;
        logic [63:0] npc;

        @(negedge clk);
        do_reset();

        // addi with immediate ack
        build_instr(c_ADDI, 64'h8000_0004, 0, 0); play(1000);
        // load with delayed data ack
        build_instr(c_LOAD, 64'h8000_0008, 0, 3); play(1000);
        // store then branch
        build_instr(c_STORE, 64'h8000_000C, 0, 0); play(1000);
        build_instr(c_BR, 64'h8000_0100, 1, 0); play(1000);
        // ebreak stays halted for 20 cycles
        build_instr(c_EBRK, 64'h8000_0104, 0, 0); build_idle(20); play(1000);
        do_reset();
        // illegal opcode
        build_instr(7'b0000000, 64'h8000_0004, 0, 0); build_idle(4); play(1000);
        do_reset();
        // fetch ack on the 16th request cycle wins, one cycle later traps
        build_instr(c_ADDI, 64'h8000_0004, c_TIMEOUT - 1, 0); play(1000);
        build_instr(c_ADDI, 64'h8000_0008, c_TIMEOUT, 0); build_idle(4); play(1000);
        do_reset();
        // data-side timeout on a store
        build_instr(c_STORE, 64'h8000_0004, 0, c_TIMEOUT); build_idle(3); play(1000);
        do_reset();
        // reset in the middle of a stalled load
        build_instr(c_LOAD, 64'h8000_0004, 0, 10); play(5);
        do_reset();
        build_instr(c_ADDI, 64'h8000_0004, 0, 0); play(1000);

        // randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            if (m_mode != 0) begin
                build_idle(3); play(1000);
                do_reset();
            end
            sel = $urandom_range(0, 24);
            if (sel == 0)      op = c_EBRK;
            else if (sel == 1) op = rnd_op();
            else               op = legal_ops[$urandom_range(0, 8)];
            fd  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 2);
            md  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            npc = {$urandom, $urandom} & ~64'd3;
            build_instr(op, npc, fd, md);
            play(1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
